// File: rtl/decode_stream_ctrl_if.sv
// Byte-in / coefficient-out stream bundle for the ByteDecode sequencer.
// The producer of bytes and consumer of coefficients is the master side;
// the decode controller is the slave side.
interface decode_stream_ctrl_if #(
    parameter int ELL = 12
);
    logic [7:0]     in_byte;
    logic           in_valid;
    logic           in_ready;
    logic [ELL-1:0] out_coeff;
    logic [1:0]     out_poly;
    logic [7:0]     out_idx;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in_byte, in_valid, out_ready,
        input  in_ready, out_coeff, out_poly, out_idx, out_last, out_valid
    );

    modport slave (
        input  in_byte, in_valid, out_ready,
        output in_ready, out_coeff, out_poly, out_idx, out_last, out_valid
    );
endinterface

// File: rtl/decode_stream_ctrl.sv
// ByteDecode_ELL sequencer: unpacks a byte stream LSB-first into ELL-bit
// coefficients for K polynomials of NCOEFF coefficients each, tagging each
// coefficient with its polynomial/coefficient index and flagging any
// coefficient >= Q when ELL is 12.
module decode_stream_ctrl #(
    parameter int ELL    = 12,
    parameter int K      = 3,
    parameter int NCOEFF = 256,
    parameter int Q      = 3329
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 range_err,
    decode_stream_ctrl_if.slave  bus
);
    localparam int ACC_W       = ELL + 7;
    localparam int FILL_W      = $clog2(ELL + 8);
    localparam int TOTAL_BYTES = K * 32 * ELL;
    localparam int BCNT_W      = $clog2(TOTAL_BYTES + 1);

    localparam logic [FILL_W-1:0] ELL_F    = FILL_W'(ELL);
    localparam logic [BCNT_W-1:0] BCNT_END = BCNT_W'(TOTAL_BYTES);
    localparam logic [1:0]        POLY_END = 2'(K - 1);
    localparam logic [7:0]        IDX_END  = 8'(NCOEFF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t              r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [FILL_W-1:0]   r_fill;
    logic [BCNT_W-1:0]   r_byte_cnt;
    logic [1:0]          r_poly;
    logic [7:0]          r_idx;
    logic                r_busy;
    logic                r_done;
    logic                r_range_err;

    logic                w_run;
    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_out_last;
    logic                w_range_hit;
    logic [ACC_W-1:0]    w_acc_shift;
    logic [FILL_W-1:0]   w_fill_shift;
    logic [ACC_W-1:0]    w_acc_next;
    logic [FILL_W-1:0]   w_fill_next;

    // Room for another byte only while fewer than ELL bits are buffered and
    // the command's byte budget is not yet exhausted.
    assign w_run       = (r_state == S_RUN);
    assign w_in_ready  = w_run && (r_fill < ELL_F) && (r_byte_cnt != BCNT_END);
    assign w_out_valid = w_run && (r_fill >= ELL_F);
    assign w_in_fire   = w_in_ready && bus.in_valid;
    assign w_out_fire  = w_out_valid && bus.out_ready;
    assign w_out_last  = w_out_valid && (r_poly == POLY_END) && (r_idx == IDX_END);
    assign w_range_hit = (ELL == 12) && w_out_fire && (32'(r_acc[ELL-1:0]) >= 32'(Q));

    // Next accumulator/fill: drop the emitted coefficient first, then append
    // an accepted byte just above the bits that remain.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_acc_shift  = r_acc;
        w_fill_shift = r_fill;
        if (w_out_fire) begin
            w_acc_shift  = r_acc >> ELL;
            w_fill_shift = r_fill - ELL_F;
        end
        w_acc_next  = w_acc_shift;
        w_fill_next = w_fill_shift;
        if (w_in_fire) begin
            w_acc_next  = w_acc_shift | (ACC_W'(bus.in_byte) << w_fill_shift);
            w_fill_next = w_fill_shift + FILL_W'(8);
        end
    end

    // Command FSM plus unpacking datapath, indices and sticky range flag.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_fill      <= '0;
            r_byte_cnt  <= '0;
            r_poly      <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_busy      <= 1'b1;
                        r_range_err <= 1'b0;
                        r_acc       <= '0;
                        r_fill      <= '0;
                        r_byte_cnt  <= '0;
                        r_poly      <= '0;
                        r_idx       <= '0;
                    end
                end
                S_RUN: begin
                    r_acc  <= w_acc_next;
                    r_fill <= w_fill_next;
                    if (w_in_fire) begin
                        r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
                    end
                    if (w_range_hit) begin
                        r_range_err <= 1'b1;
                    end
                    if (w_out_fire) begin
                        if (w_out_last) begin
                            r_state <= S_FLUSH;
                            r_done  <= 1'b1;
                            r_poly  <= '0;
                            r_idx   <= '0;
                        end else if (r_idx == IDX_END) begin
                            r_idx  <= '0;
                            r_poly <= r_poly + 2'd1;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign range_err     = r_range_err;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_coeff = r_acc[ELL-1:0];
    assign bus.out_poly  = r_poly;
    assign bus.out_idx   = r_idx;
    assign bus.out_last  = w_out_last;
endmodule

// File: tb/tb_decode_stream_ctrl.sv
// Self-checking bench for decode_stream_ctrl: an ELL=12 instance compared
// every cycle against a bit-stream model, plus an ELL=1 instance for the
// single-bit unpacking case.
module tb_decode_stream_ctrl;
    localparam int L           = 12;
    localparam int KP          = 3;
    localparam int NC          = 256;
    localparam int QV          = 3329;
    localparam int TOTAL_BYTES = KP * 32 * L;
    localparam int TOTAL_COEFF = KP * NC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, range_err;
    logic start1 = 1'b0;
    logic busy1, done1, range_err1;

    decode_stream_ctrl_if #(.ELL(12)) bus ();
    decode_stream_ctrl_if #(.ELL(1))  bus1 ();

    decode_stream_ctrl #(.ELL(12), .K(KP), .NCOEFF(NC), .Q(QV)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .range_err(range_err), .bus(bus)
    );

    decode_stream_ctrl #(.ELL(1), .K(KP), .NCOEFF(NC), .Q(QV)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .range_err(range_err1), .bus(bus1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus driver (ELL=12 instance) ----------------
    logic [7:0] byte_q[$];
    bit         feed_rand  = 1'b0;
    int         ready_mode = 0;   // 0: always ready, 1: random, 2: held low

    initial begin
        bit fire;
        bus.in_valid  = 1'b0;
        bus.in_byte   = 8'h00;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            fire = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (fire && byte_q.size() > 0) void'(byte_q.pop_front());
            bus.in_valid = (byte_q.size() > 0) && (!feed_rand || ($urandom_range(0, 3) != 0));
            bus.in_byte  = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 2) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    // The model sees the accepted bytes as one little-endian bit string;
    // coefficient n is bits [12n+11 : 12n] of that string.
    logic [7:0]  m_mem [0:TOTAL_BYTES-1];
    int          m_bytes = 0;
    int          m_emit  = 0;
    bit          m_run   = 1'b0;
    bit          m_flush = 1'b0;
    bit          m_rerr  = 1'b0;
    logic [11:0] got_q[$];

    function automatic logic [11:0] model_coeff(input int n);
        logic [11:0] c;
        logic [7:0]  b;
        int          bit_pos;
        c = '0;
        for (int j = 0; j < L; j++) begin
            bit_pos = n * L + j;
            b = m_mem[bit_pos / 8];
            c[j] = b[bit_pos % 8];
        end
        return c;
    endfunction

    always @(negedge clk) begin
        int avail;
        bit idle, e_ir, e_ov, in_fire, out_fire, next_flush;
        if (rst) begin
            check("rst_in_ready", bus.in_ready, 0);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_range_err", range_err, 0);
            m_run = 0; m_flush = 0; m_rerr = 0; m_bytes = 0; m_emit = 0;
        end else begin
            idle  = !m_run && !m_flush;
            avail = 8 * m_bytes - L * m_emit;
            e_ir  = m_run && (avail < L) && (m_bytes < TOTAL_BYTES);
            e_ov  = m_run && (avail >= L);
            check("in_ready", bus.in_ready, e_ir);
            check("out_valid", bus.out_valid, e_ov);
            check("busy", busy, m_run || m_flush);
            check("done", done, m_flush);
            check("range_err", range_err, m_rerr);
            check("out_last", bus.out_last, e_ov && (m_emit == TOTAL_COEFF - 1));
            if (e_ov) begin
                check("out_coeff", bus.out_coeff, model_coeff(m_emit));
                check("out_poly", bus.out_poly, m_emit / NC);
                check("out_idx", bus.out_idx, m_emit % NC);
            end
            in_fire    = e_ir && bus.in_valid;
            out_fire   = e_ov && bus.out_ready;
            next_flush = 1'b0;
            if (in_fire) begin
                m_mem[m_bytes] = bus.in_byte;
                m_bytes++;
            end
            if (out_fire) begin
                got_q.push_back(bus.out_coeff);
                if (model_coeff(m_emit) >= QV) m_rerr = 1'b1;
                m_emit++;
                if (m_emit == TOTAL_COEFF) begin
                    m_run      = 1'b0;
                    next_flush = 1'b1;
                end
            end
            if (idle && start) begin
                m_run = 1'b1; m_bytes = 0; m_emit = 0; m_rerr = 1'b0;
                got_q.delete();
            end
            m_flush = next_flush;
        end
    end

    // ---------------- helpers ----------------
    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_coeffs(input int n, input int budget, input string name);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        check(name, (got_q.size() >= n), 1);
    endtask

    task automatic wait_done(input int budget, input string name);
        int c = 0;
        while (!done && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, done, 1);
    endtask

    task automatic load_random(input int n);
        for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [11:0] hold_coeff;
        logic [7:0]  hold_idx, b0, b1, pat;
        int          got1, c;
        bit          acc_b;

        bus1.in_valid = 1'b0; bus1.in_byte = 8'h00; bus1.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_out_coeff", bus.out_coeff, 0);
        check("rst_out_poly", bus.out_poly, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_out_last", bus.out_last, 0);
        rst = 1'b0;

        // T1/T2 prefix of a full command, then T3 with random stalls
        byte_q = {8'h01, 8'h23, 8'h45, 8'hFF, 8'hFF, 8'hFF};
        load_random(TOTAL_BYTES - 6);
        feed_rand = 1'b0; ready_mode = 0;
        pulse_start();
        wait_coeffs(2, 200, "t1_wait");
        #1;
        check("t1_coeff0", got_q[0], 12'h301);
        check("t1_coeff1", got_q[1], 12'h452);
        check("t1_range_err", range_err, 0);
        wait_coeffs(4, 200, "t2_wait");
        #1;
        check("t2_coeff2", got_q[2], 12'hFFF);
        check("t2_coeff3", got_q[3], 12'hFFF);
        check("t2_range_err", range_err, 1);
        feed_rand = 1'b1; ready_mode = 1;
        wait_done(20000, "t3_done");
        check("t3_ncoeff", got_q.size(), TOTAL_COEFF);
        #1 start = 1'b1;                       // start during the done pulse
        @(posedge clk); #2 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t3_busy_after", busy, 0);
        check("t2_sticky", range_err, 1);

        // Second command: start clears range_err, T5 stall, T6 reset mid-poly
        load_random(TOTAL_BYTES);
        feed_rand = 1'b0; ready_mode = 0;
        pulse_start();
        check("start_clears_rerr", range_err, 0);
        wait_coeffs(50, 400, "t5_wait");
        ready_mode = 2;
        @(posedge clk); #3;
        c = 0;
        while (!bus.out_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("t5_valid_seen", bus.out_valid, 1);
        hold_coeff = bus.out_coeff;
        hold_idx   = bus.out_idx;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_coeff_stable", bus.out_coeff, hold_coeff);
            check("t5_idx_stable", bus.out_idx, hold_idx);
            check("t5_in_ready_low", bus.in_ready, 0);
        end
        ready_mode = 0;
        wait_coeffs(NC + 100, 2000, "t6_wait");
        #2 rst = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_in_ready", bus.in_ready, 0);
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_out_coeff", bus.out_coeff, 0);
        check("t6_out_poly", bus.out_poly, 0);
        check("t6_out_idx", bus.out_idx, 0);
        check("t6_out_last", bus.out_last, 0);
        byte_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Third command after reset: decodes from poly0 idx0, start while busy ignored
        load_random(TOTAL_BYTES);
        b0 = byte_q[0];
        b1 = byte_q[1];
        feed_rand = 1'b1; ready_mode = 1;
        pulse_start();
        wait_coeffs(1, 200, "t6_first_wait");
        check("t6_first_coeff", got_q[0], {b1[3:0], b0});
        wait_coeffs(10, 400, "busy_start_wait");
        pulse_start();
        wait_done(20000, "t6_done");
        check("t6_ncoeff", got_q.size(), TOTAL_COEFF);

        // T4: ELL=1 unpacks 0xA5 LSB-first
        pat = 8'hA5;
        @(posedge clk); #2 start1 = 1'b1;
        @(posedge clk); #2 start1 = 1'b0;
        bus1.in_byte = 8'hA5; bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
        got1 = 0;
        for (int k = 0; k < 40 && got1 < 8; k++) begin
            @(negedge clk);
            acc_b = bus1.in_valid && bus1.in_ready;
            if (bus1.out_valid) begin
                check("t4_coeff", bus1.out_coeff, pat[got1]);
                check("t4_idx", bus1.out_idx, got1);
                check("t4_poly", bus1.out_poly, 0);
                got1++;
            end
            @(posedge clk);
            #2;
            if (acc_b) bus1.in_valid = 1'b0;
        end
        check("t4_count", got1, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
